// File: rtl/ram_rd_check.sv
// ram_rd_check: shadows RAM port-A writes and checks read data (ports: clka/rst, snooped ena/wea/addra/dina, douta in; err, err_cnt, pass_cnt, pass_done, first_err_addr/data, state out)
module ram_rd_check #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic              pass_done,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic [1:0]        state
);
  localparam int L = RD_LAT - 1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
  state_t cur, nxt;
  logic [DATA_W-1:0] shadow [2**ADDR_W];
  logic [2**ADDR_W-1:0] valid;
  logic [RD_LAT-1:0] p_vld;
  logic [ADDR_W-1:0] p_addr [RD_LAT];
  logic [DATA_W-1:0] p_exp [RD_LAT];
  logic pass_bad, live, cmp, mis, pass_end;
  assign live = cur != HALT;
  assign cmp = live && p_vld[L];
  assign mis = cmp && douta != p_exp[L];
  assign pass_end = cmp && &p_addr[L];
  assign state = cur;
  always_comb begin
    nxt = cur;
    nxt = (cur == IDLE && ena) ? RUN : (cur == RUN && mis && STOP_ON_ERR) ? HALT : cur;
  end
  always_ff @(posedge clka)
    if (rst) cur <= IDLE;
    else cur <= nxt;
  always_ff @(posedge clka) begin
    if (!rst && live && ena && wea) shadow[addra] <= dina;
    p_addr[0] <= addra;
    p_exp[0] <= shadow[addra];
    for (int i = 1; i < RD_LAT; i++) begin
      p_addr[i] <= p_addr[i-1];
      p_exp[i] <= p_exp[i-1];
    end
  end
  always_ff @(posedge clka)
    if (rst) begin
      valid <= '0;
      p_vld <= '0;
      err <= 1'b0;
      err_cnt <= '0;
      pass_cnt <= '0;
      pass_done <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
      pass_bad <= 1'b0;
    end else begin
      if (live && ena && wea) valid[addra] <= 1'b1;
      p_vld[0] <= live && ena && !wea && valid[addra];
      for (int i = 1; i < RD_LAT; i++) p_vld[i] <= p_vld[i-1];
      if (mis) begin
        err <= 1'b1;
        if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
        if (!err) begin
          first_err_addr <= p_addr[L];
          first_err_data <= douta;
        end
      end
      pass_done <= pass_end;
      if (pass_end && !pass_bad && !mis && ~&pass_cnt) pass_cnt <= pass_cnt + 1'b1;
      pass_bad <= pass_end ? 1'b0 : pass_bad | mis;
    end
endmodule

// File: tb/tb_ram_rd_check.sv
// tb_ram_rd_check: scoreboard bench driving two checker instances (long latency/no stop, short latency/stop on error)
module tb_ram_rd_check;
  localparam int AW = 5, DW = 8, N = 32, LA = 3, LB = 1;
  logic clka = 0, rst = 1, ena = 0, wea = 0;
  logic [AW-1:0] addra = '0;
  logic [DW-1:0] dina = '0, douta_a = '0, douta_b = '0;
  logic err_a, err_b, pd_a, pd_b;
  logic [3:0] ec_a, pc_a;
  logic [15:0] ec_b, pc_b;
  logic [AW-1:0] fa_a, fa_b;
  logic [DW-1:0] fd_a, fd_b;
  logic [1:0] st_a, st_b;
  always #5 clka = ~clka;
  ram_rd_check #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LA), .CNT_W(4), .STOP_ON_ERR(1'b0)) u_a (
    .clka(clka), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_a),
    .err(err_a), .err_cnt(ec_a), .pass_cnt(pc_a), .pass_done(pd_a),
    .first_err_addr(fa_a), .first_err_data(fd_a), .state(st_a));
  ram_rd_check #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LB), .CNT_W(16), .STOP_ON_ERR(1'b1)) u_b (
    .clka(clka), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_b),
    .err(err_b), .err_cnt(ec_b), .pass_cnt(pc_b), .pass_done(pd_b),
    .first_err_addr(fa_b), .first_err_data(fd_b), .state(st_b));
  typedef struct {int due; bit e; int ec; int pc; bit pd; int fa; int fd; int st;} ent_t;
  ent_t sb0[$], sb1[$];
  int cyc = 0, checks = 0, errors = 0;
  logic [DW-1:0] mem [N];
  bit wr [2][N];
  bit m_err [2], m_bad [2], m_halt [2], last_e [2];
  int m_ec [2], m_pc [2], m_fa [2], m_fd [2], last_ec [2], last_pc [2];
  logic [DW-1:0] line_a [LA], line_b [LB];
  always @(posedge clka) cyc <= cyc + 1;
  task automatic chk(int d, string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0d expected %0d at cycle %0d", d, nm, act, exp, cyc);
    end
  endtask
  task automatic model_rd(int d, int due, int ad, int ret);
    ent_t x;
    bit mis, top;
    int cmax;
    if (!wr[d][ad] || m_halt[d]) return;
    cmax = d == 0 ? 15 : 65535;
    mis = ret != int'(mem[ad]);
    top = ad == N - 1;
    if (mis && !m_err[d]) begin
      m_fa[d] = ad;
      m_fd[d] = ret;
    end
    if (mis) begin
      m_err[d] = 1;
      m_ec[d] = m_ec[d] < cmax ? m_ec[d] + 1 : cmax;
    end
    if (top) begin
      if (!m_bad[d] && !mis && m_pc[d] < cmax) m_pc[d]++;
      m_bad[d] = 0;
    end else m_bad[d] |= mis;
    if (mis && d == 1) m_halt[d] = 1;
    x = '{due, m_err[d], m_ec[d], m_pc[d], top, m_fa[d], m_fd[d], m_halt[d] ? 2 : 1};
    if (d == 0) sb0.push_back(x);
    else sb1.push_back(x);
  endtask
  task automatic step(bit en, bit we, int ad, int di, int xa, int xb);
    int e;
    logic [DW-1:0] ra, rb;
    e = cyc + 1;
    ena = en;
    wea = we;
    addra = AW'(ad);
    dina = DW'(di);
    ra = mem[ad] ^ DW'(xa);
    rb = mem[ad] ^ DW'(xb);
    if (en && !we && !rst) begin
      model_rd(0, e + LA, ad, int'(ra));
      model_rd(1, e + LB, ad, int'(rb));
    end
    if (en && we && !rst) begin
      mem[ad] = DW'(di);
      wr[0][ad] = 1;
      wr[1][ad] = 1;
    end
    @(posedge clka);
    #1;
    for (int i = LA - 1; i > 0; i--) line_a[i] = line_a[i-1];
    for (int i = LB - 1; i > 0; i--) line_b[i] = line_b[i-1];
    line_a[0] = (en && !we) ? ra : DW'($urandom);
    line_b[0] = (en && !we) ? rb : DW'($urandom);
    douta_a = line_a[LA-1];
    douta_b = line_b[LB-1];
  endtask
  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    rst = 1;
    sb0.delete();
    sb1.delete();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) wr[d][i] = 0;
      m_err[d] = 0; m_bad[d] = 0; m_halt[d] = 0; m_ec[d] = 0; m_pc[d] = 0; m_fa[d] = 0; m_fd[d] = 0;
      last_e[d] = 0; last_ec[d] = 0; last_pc[d] = 0;
    end
    idle(1);
    rst = 0;
  endtask
  task automatic mon(int d, bit e, int ec, int pc, bit pd, int fa, int fd, int st);
    ent_t x;
    bit have;
    have = 0;
    if (d == 0 && sb0.size() > 0 && sb0[0].due <= cyc) begin x = sb0.pop_front(); have = 1; end
    if (d == 1 && sb1.size() > 0 && sb1[0].due <= cyc) begin x = sb1.pop_front(); have = 1; end
    if (have) begin
      chk(d, "compare slot", cyc, x.due);
      chk(d, "err", e, x.e);
      chk(d, "err_cnt", ec, x.ec);
      chk(d, "pass_cnt", pc, x.pc);
      chk(d, "pass_done", pd, x.pd);
      chk(d, "first_err_addr", fa, x.fa);
      chk(d, "first_err_data", fd, x.fd);
      chk(d, "state", st, x.st);
      last_e[d] = x.e;
      last_ec[d] = x.ec;
      last_pc[d] = x.pc;
    end else begin
      chk(d, "pass_done quiet", pd, 0);
      chk(d, "err hold", e, last_e[d]);
      chk(d, "err_cnt hold", ec, last_ec[d]);
      chk(d, "pass_cnt hold", pc, last_pc[d]);
    end
  endtask
  always @(negedge clka)
    if (!rst) begin
      mon(0, err_a, ec_a, pc_a, pd_a, fa_a, fd_a, st_a);
      mon(1, err_b, ec_b, pc_b, pd_b, fa_b, fd_b, st_b);
    end
  initial begin
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < LA; i++) line_a[i] = '0;
    for (int i = 0; i < LB; i++) line_b[i] = '0;
    do_reset();
    chk(0, "reset state", st_a, 0);
    chk(1, "reset state", st_b, 0);
    chk(0, "reset err", err_a, 0);
    chk(1, "reset pass_cnt", pc_b, 0);
    for (int p = 0; p < 3; p++) begin
      for (int a = 0; a < N; a++) step(1, 1, a, a, 0, 0);
      for (int a = 0; a < N; a++)
        step(1, 0, a, 0, (p == 1 && a == 7) ? (7 ^ 8'hA5) : 0, (p == 0 && (a == 3 || a == 9)) ? 8'h3C : 0);
    end
    idle(5);
    chk(0, "gen pass_cnt", pc_a, 2);
    chk(0, "gen err_cnt", ec_a, 1);
    chk(0, "gen err", err_a, 1);
    chk(0, "gen first_err_addr", fa_a, 7);
    chk(0, "gen first_err_data", fd_a, 8'hA5);
    chk(1, "stop state", st_b, 2);
    chk(1, "stop err_cnt", ec_b, 1);
    chk(1, "stop first_err_addr", fa_b, 3);
    chk(1, "stop pass_cnt", pc_b, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, N - 1), $urandom,
           $urandom_range(0, 5) == 0 ? $urandom_range(1, 255) : 0, 0);
    idle(5);
    chk(0, "saturated err_cnt", ec_a, 15);
    chk(1, "halt err_cnt frozen", ec_b, 1);
    do_reset();
    for (int a = 0; a < N; a++) step(1, 0, a, 0, 8'hFF, 8'hFF);
    idle(5);
    chk(0, "unwritten err_cnt", ec_a, 0);
    chk(1, "unwritten err", err_b, 0);
    chk(1, "unwritten state", st_b, 1);
    step(1, 1, 5, 8'h55, 0, 0);
    step(1, 0, 5, 0, 8'h0F, 8'h0F);
    do_reset();
    idle(5);
    chk(0, "inflight err", err_a, 0);
    chk(0, "inflight err_cnt", ec_a, 0);
    chk(0, "inflight first_err_data", fd_a, 0);
    chk(0, "inflight state", st_a, 0);
    chk(1, "inflight err", err_b, 0);
    for (int a = 0; a < N; a++) step(1, 1, a, $urandom, 0, 0);
    for (int a = 0; a < N; a++) step(1, 0, a, 0, 0, 0);
    idle(5);
    chk(0, "clean pass_cnt", pc_a, 1);
    chk(1, "clean pass_cnt", pc_b, 1);
    chk(0, "clean err", err_a, 0);
    chk(0, "scoreboard drained", sb0.size(), 0);
    chk(1, "scoreboard drained", sb1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
